// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the copperv instruction fetch front end: bus width,
// PC increment, fetch FSM state encoding and the instruction buffer entry.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int bus_width = 32;

    // Byte distance between consecutive instructions (PC increment).
    localparam logic [bus_width-1:0] inst_bytes = 32'd4;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_FULL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [bus_width-1:0] inst;
        logic [bus_width-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous FIFO of {instruction, pc} pairs between the read-data bus and
// the decoder. Flush empties the FIFO and overrides push and pop on the same
// edge. Push while full is honoured only together with a pop.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   push, push_inst/pc  write an entry
//   pop                 remove the head entry
//   flush               empty the FIFO
//   head_inst/pc        head entry (undefined while empty)
//   full, empty, count  occupancy
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int depth = 2,
    localparam int ptr_w = $clog2(depth),
    localparam int cnt_w = $clog2(depth) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [bus_width-1:0] push_inst,
    input  logic [bus_width-1:0] push_pc,
    input  logic                 pop,
    input  logic                 flush,
    output logic [bus_width-1:0] head_inst,
    output logic [bus_width-1:0] head_pc,
    output logic                 full,
    output logic                 empty,
    output logic [cnt_w-1:0]     count
);

    fetch_entry_t     mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == cnt_w'(depth));
    assign empty   = (count == '0);
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // depth is a power of two, so the pointers wrap for free.
            if (do_push) wr_ptr <= wr_ptr + ptr_w'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_w'(1);
            count <= count + cnt_w'(do_push) - cnt_w'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; entries are only observable
    // once count marks them valid, so clearing them would be wasted logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{inst: push_inst, pc: push_pc};
    end

    assign head_inst = mem[rd_ptr].inst;
    assign head_pc   = mem[rd_ptr].pc;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end of the copperv core. Holds the fetch PC, issues
// one read at a time on the read-address/read-data bus, buffers returned
// words with their PC and hands them to the decoder over valid/ready.
// A redirect (pc_load) flushes the buffer and drops any in-flight response.
//
// Optional feature (macro COPPERV_FETCH_MISALIGN_EN): adds fetch_misaligned;
// a redirect to a non word-aligned target raises it and stalls requests until
// a redirect to an aligned target.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   pc_load, pc_target            redirect strobe and address
//   inst_valid/ready, inst, inst_pc   decoder handshake and head entry
//   raddr_valid/ready, raddr      read request channel
//   rdata_valid/ready, rdata      read response channel
//   fetch_misaligned              (optional) misaligned redirect flag
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [bus_width-1:0] reset_pc = '0,
    parameter int                   depth    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_load,
    input  logic [bus_width-1:0] pc_target,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [bus_width-1:0] inst,
    output logic [bus_width-1:0] inst_pc,
    output logic                 raddr_valid,
    input  logic                 raddr_ready,
    output logic [bus_width-1:0] raddr,
    input  logic                 rdata_valid,
    output logic                 rdata_ready,
    input  logic [bus_width-1:0] rdata
`ifdef COPPERV_FETCH_MISALIGN_EN
    ,
    output logic                 fetch_misaligned
`endif
);

    localparam int cnt_w = $clog2(depth) + 1;

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic [bus_width-1:0] req_pc;
    logic                 discard;
    logic                 misaligned;
    logic                 target_misaligned;

    logic                 addr_hs;
    logic                 data_hs;
    logic                 pop;
    logic                 push;
    logic                 outstanding_after;
    logic [cnt_w-1:0]     count_after;

    logic [bus_width-1:0] head_inst;
    logic [bus_width-1:0] head_pc;
    logic                 buf_full;
    logic                 buf_empty;
    logic [cnt_w-1:0]     buf_count;

    assign addr_hs = raddr_valid && raddr_ready;
    assign data_hs = rdata_valid && rdata_ready;
    assign pop     = inst_valid && inst_ready;
    assign push    = data_hs && !discard;

    // A read is still in flight after this edge if one is accepted now, or if
    // we are waiting and the response does not handshake on this edge.
    assign outstanding_after = addr_hs || ((state == FETCH_WAIT) && !data_hs);

    // Buffer occupancy after this edge, ignoring a redirect flush.
    assign count_after = buf_count + cnt_w'(push) - cnt_w'(pop && !buf_empty);

`ifdef COPPERV_FETCH_MISALIGN_EN
    assign target_misaligned = (pc_target[1:0] != 2'b00);
    assign fetch_misaligned  = misaligned;
`else
    assign target_misaligned = 1'b0;
`endif

    fetch_buffer #(.depth(depth)) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_inst (rdata),
        .push_pc   (req_pc),
        .pop       (pop),
        .flush     (pc_load),
        .head_inst (head_inst),
        .head_pc   (head_pc),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH_REQ;
        else      state <= state_next;
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_REQ:  if (addr_hs) state_next = FETCH_WAIT;
            FETCH_WAIT: if (data_hs)
                            state_next = (count_after < cnt_w'(depth)) ? FETCH_REQ : FETCH_FULL;
            FETCH_FULL: if (pop) state_next = FETCH_REQ;
            default:    state_next = FETCH_REQ;
        endcase
        // A redirect flushes the buffer, so only an in-flight read keeps us waiting.
        if (pc_load) state_next = outstanding_after ? FETCH_WAIT : FETCH_REQ;
    end

    // Output logic. rst gates raddr_valid so no request is offered while held
    // in reset, even though the state register already sits in FETCH_REQ.
    always_comb begin
        raddr_valid = 1'b0;
        rdata_ready = 1'b0;
        case (state)
            FETCH_REQ:  raddr_valid = rst && !buf_full && !misaligned;
            FETCH_WAIT: rdata_ready = 1'b1;
            default:    ;
        endcase
        inst_valid = !buf_empty;
        inst       = buf_empty ? '0 : head_inst;
        inst_pc    = buf_empty ? '0 : head_pc;
    end

    // Fetch PC, request PC and discard tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raddr      <= reset_pc;
            req_pc     <= '0;
            discard    <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            if (addr_hs) req_pc <= raddr;
            if (pc_load) begin
                raddr      <= pc_target;
                // Stays set across back-to-back redirects until the single
                // outstanding response has been consumed.
                discard    <= outstanding_after;
                misaligned <= target_misaligned;
            end else begin
                if (addr_hs) raddr <= raddr + inst_bytes;
                if (data_hs) discard <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end of the copperv core.
- Holds the fetch PC and issues read requests on the native read-address/read-data bus to the instruction memory.
- Buffers returned words in a small FIFO and presents them with their PC to the decoder over a valid/ready handshake.
- Handles PC redirects (branch/jump) by flushing the buffer and discarding in-flight responses.

Parameters:
- reset_pc, 0, first fetch address after reset.
- depth, 2, instruction buffer entries (power of two, >= 2).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- pc_load  input  1  redirect strobe.
- pc_target  input  `BUS_WIDTH  redirect address.
- inst_valid  output  1  buffer head valid.
- inst_ready  input  1  decoder accepts head.
- inst  output  `BUS_WIDTH  instruction word at head.
- inst_pc  output  `BUS_WIDTH  PC of head.
- raddr_valid  output  1  read request valid.
- raddr_ready  input  1  memory accepts request.
- raddr  output  `BUS_WIDTH  read address.
- rdata_valid  input  1  read response valid.
- rdata_ready  output  1  fetch accepts response.
- rdata  input  `BUS_WIDTH  read response word.

Behaviour:
- Single clock clk. rst is asynchronous and active-low; all state clears immediately when rst=0.
- Reset values: raddr_valid=0, raddr=reset_pc, rdata_ready=0, inst_valid=0, inst=0, inst_pc=0, buffer empty, discard=0, state=REQ.
- At most one outstanding read at any time.
- A request is issued only when count + outstanding < depth. rdata_ready is therefore 1 whenever a response is outstanding or being discarded, so responses are never back-pressured.
- FSM states:
  - REQ: raddr_valid=1 while a buffer slot is reserved-free. On raddr_valid && raddr_ready: record req_pc=raddr, raddr<=raddr+4, go to WAIT.
  - WAIT: rdata_ready=1. On rdata_valid: if discard=0, push {rdata, req_pc}; clear discard; go to REQ if space remains, else FULL.
  - FULL: raddr_valid=0. Go to REQ on the edge where a pop frees a slot.
- Latency: address accepted at edge N (memory responds next cycle), response handshake at edge N+1, inst_valid=1 after edge N+1. Sustained throughput is one word per 2 cycles.
- Pop: inst_valid && inst_ready removes the head. Push and pop on the same edge are both honoured; count is unchanged.
- Redirect: at an edge with pc_load=1:
  - raddr<=pc_target.
  - Buffer flushed (count=0); a simultaneous pop is ignored.
  - Any request accepted at or before that edge whose data has not yet handshaken sets discard=1. Its response is consumed with rdata_ready=1 but not pushed.
  - Next state: REQ if nothing outstanding; otherwise stay in WAIT.
- pc_load in the same edge as a raddr handshake: the request is outstanding and discarded; next request uses pc_target.
- Back-to-back pc_load: the last one wins; discard stays set until the single outstanding response returns.
- raddr is stable while raddr_valid=1 unless pc_load is asserted.
- PC arithmetic wraps modulo 2^`BUS_WIDTH; 0xFFFFFFFC+4 = 0.
- Buffer pointers wrap modulo depth. Full at count=depth, empty at count=0.

Optional Feature:
COPPERV_FETCH_MISALIGN_EN
- Enabled:
  - Adds output port fetch_misaligned (1 bit, reset 0).
  - A pc_load with pc_target[1:0]!=0 sets fetch_misaligned=1 and flushes the buffer; requests are suppressed.
  - fetch_misaligned clears on the next pc_load with an aligned target, and fetch resumes normally.
- Disabled: the port is absent; addresses are issued exactly as given, with no alignment check.

Decomposition:
- Shared header copperv_h.v holds `BUS_WIDTH, `TRUE, and fetch FSM state encodings (FETCH_REQ, FETCH_WAIT, FETCH_FULL) plus the instruction-width constant 4 (PC increment).
- One sub-module: fetch_buffer.
  - Synchronous FIFO of {inst, pc}, parameter depth.
  - Ports: push, pop, flush, full, empty, count.
  - Flush overrides push and pop.

Test Plan:
- Reset release with reset_pc=0x100, memory raddr_ready=1, inst_ready=1 -> raddr sequence 0x100, 0x104, 0x108; inst_pc follows the same; first inst_valid 2 cycles after reset release; one instruction every 2 cycles.
- inst_ready=0 for 10 cycles, depth=2 -> exactly 2 requests issued, then raddr_valid=0 (FULL). Raise inst_ready -> pops 0x100, 0x104 in order, then requests resume at 0x108.
- pc_load=1, pc_target=0x40 during WAIT for 0x10C -> 0x10C response consumed but not delivered; next raddr=0x40; next delivered inst_pc=0x40.
- pc_load on the same edge as a pop with a full buffer -> buffer empty next cycle, popped entry not duplicated, first delivered inst_pc=pc_target.
- PC wrap: pc_load to 0xFFFFFFFC -> delivered inst_pc values 0xFFFFFFFC, 0x00000000.
- With COPPERV_FETCH_MISALIGN_EN: pc_load 0x42 -> fetch_misaligned=1, raddr_valid=0. Then pc_load 0x44 -> flag clears, raddr=0x44 issued.
